axi4_lite_lstm_capture: RTL and testbench
=========================================

// Module: axi4_lite_lstm_capture
// PURPOSE
//  AXI4-Lite-readable capture FIFO for LSTM layer outputs. It samples either y_out or one selected
//  debug channel on its valid strobe and stores tagged samples in a FIFO. Software drains the FIFO
//  via register reads and gets per-sample counters, overflow status and a level interrupt.
//  Sits beside axi4_lite_lstm_layers on the same bus; generalises its fixed 16-bit x4 debug taps.
// PARAMETERS
//  DATA_WIDTH  16  sample width of y_in and of each debug channel (2..24)
//  CHANNELS    4   number of debug channels (1..16)
//  FIFO_DEPTH  64  capture FIFO entries; power of 2, >=2
// PORTS
//  clk             in   1                      clock
//  rst_n           in   1                      async reset, active-low
//  awaddr/awprot/awvalid/awready, wdata/wstrb/wvalid/wready, bresp/bvalid/bready,
//  araddr/arprot/arvalid/arready, rdata/rresp/rvalid/rready  AXI4-Lite slave, 32-bit addr/data
//  y_in            in   DATA_WIDTH             LSTM output sample, signed
//  y_in_valid      in   1                      y_in qualifier
//  debug_in        in   CHANNELS*DATA_WIDTH    debug taps, channel k at [k*DATA_WIDTH +: DATA_WIDTH]
//  debug_in_valid  in   CHANNELS               per-channel qualifiers
//  irq             out  1                      level interrupt, registered
// BEHAVIOUR
//  Reset: all ready/valid outputs 0, rdata 0, bresp/rresp 0, irq 0; FIFO empty; all regs 0.
//  Register map (addr[7:2]; only addr[7:0] decoded; unmapped -> SLVERR 2'b10, no side effect):
//   0x00 CTRL   RW  [0] enable, [1] src (0=y_in, 1=debug), [7:4] chan sel, [8] irq_en,
//                   [31] flush (write-1, self-clearing, reads 0)
//   0x04 STATUS RO  [0] empty, [1] full, [2] overflow sticky (W1C via write to 0x04 bit2),
//                   [31:16] level
//   0x08 DATA   RO  pop: [23:0] sample sign-extended, [27:24] tag (chan, 0xF for y_in), [31] valid
//   0x0C COUNT  RO  samples pushed, 32-bit wrapping
//   0x10 DROP   RO  samples dropped due to full, 32-bit wrapping
//   0x14 THRESH RW  [15:0] irq level threshold
//  wstrb honoured per byte on CTRL/THRESH. Writes to other RO regs: OKAY, ignored.
//  Write channel:
//   - awready=wready=1 for exactly one cycle when idle and awvalid&wvalid both high.
//   - bvalid the next cycle, held until bready; no new write accepted while bvalid=1.
//  Read channel:
//   - arready=1 for one cycle when arvalid and rvalid=0.
//   - rdata/rresp registered, rvalid next cycle, held stable until rready.
//   - DATA pop occurs at AR accept.
//   - Empty DATA read returns 0 (valid=0), no pop.
//  Capture:
//   - When enable=1, push on y_in_valid (src=0) or debug_in_valid[sel] (src=1).
//   - sel>=CHANNELS never captures. At most one push per cycle.
//  Full: push dropped, DROP++, overflow=1; push+pop same cycle when full -> both occur,
//   no drop, level unchanged.
//  Flush: empties FIFO, zeroes COUNT/DROP/overflow; a push in the flush cycle is discarded and
//   not counted. CTRL other bits take written value in same write.
//  irq = irq_en & (THRESH!=0) & (level>=THRESH), registered (1 cycle after level change).
//  Level/STATUS reflect a push on the cycle after the valid strobe.
//  Mid-operation rst_n assertion: immediate return to reset state, outstanding AXI txn abandoned.
// TESTING
//  1 reset, read STATUS -> rdata=0x0000_0001 (empty), irq=0, all valids 0 after rst_n deassert.
//  2 CTRL=0x1, pulse y_in=-3 (16'hFFFD) -> level 1; DATA read = 0x8FFF_FFFD; COUNT=1; STATUS empty.
//  3 CTRL=0x23 (debug, sel 2), valids on ch 0,1,2 -> only ch2 stored, tag=2; sel=5 w/ CHANNELS=4 -> none.
//  4 fill 64 y_in, push 3 more -> full, DROP=3, overflow=1; push+pop same cycle at full -> DROP stays 3.
//  5 THRESH=4, irq_en, 4 pushes -> irq rises 1 cycle after 4th level update; one DATA pop -> irq falls.
//  6 read 0x40 -> rresp=2'b10; write with bready held low 5 cycles -> bvalid held, 2nd aw not accepted.

Source files
------------

// File: rtl/axi4_lite_lstm_capture.sv
// AXI4-Lite readable capture FIFO for LSTM outputs.
// Samples y_in or one debug tap into a tagged FIFO with counters and irq.
module axi4_lite_lstm_capture #(
  parameter int DATA_WIDTH = 16,
  parameter int CHANNELS   = 4,
  parameter int FIFO_DEPTH = 64
) (
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic [31:0]                    awaddr,
  input  logic [2:0]                     awprot,
  input  logic                           awvalid,
  output logic                           awready,
  input  logic [31:0]                    wdata,
  input  logic [3:0]                     wstrb,
  input  logic                           wvalid,
  output logic                           wready,
  output logic [1:0]                     bresp,
  output logic                           bvalid,
  input  logic                           bready,
  input  logic [31:0]                    araddr,
  input  logic [2:0]                     arprot,
  input  logic                           arvalid,
  output logic                           arready,
  output logic [31:0]                    rdata,
  output logic [1:0]                     rresp,
  output logic                           rvalid,
  input  logic                           rready,
  input  logic [DATA_WIDTH-1:0]          y_in,
  input  logic                           y_in_valid,
  input  logic [CHANNELS*DATA_WIDTH-1:0] debug_in,
  input  logic [CHANNELS-1:0]            debug_in_valid,
  output logic                           irq
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int LW = AW + 1;
  localparam int EW = DATA_WIDTH + 4;
  localparam logic [LW-1:0] FULL_LVL = LW'(FIFO_DEPTH);

  logic            enable;
  logic            src;
  logic [3:0]      sel;
  logic            irq_en;
  logic [15:0]     thresh;
  logic            overflow;
  logic [31:0]     push_cnt;
  logic [31:0]     drop_cnt;
  logic [AW-1:0]   wr_ptr;
  logic [AW-1:0]   rd_ptr;
  logic [LW-1:0]   level;
  logic [EW-1:0]   mem [FIFO_DEPTH];

  logic            wr_fire;
  logic            rd_fire;
  logic [5:0]      w_idx;
  logic [5:0]      r_idx;
  logic            flush;
  logic            full;
  logic            empty;
  logic            pop;
  logic            dbg_valid;
  logic [DATA_WIDTH-1:0] dbg_sample;
  logic            push_req;
  logic            push_ok;
  logic            drop;
  logic [EW-1:0]   entry;
  logic [EW-1:0]   head;
  logic [31:0]     rd_word;
  logic            rd_err;
  logic            unused_bits;

  assign unused_bits = ^{awprot, arprot, awaddr[31:8], awaddr[1:0],
                         araddr[31:8], araddr[1:0], wdata[30:16],
                         wstrb[2]};

  assign wr_fire = awready & awvalid & wvalid;
  assign rd_fire = arready & arvalid;
  assign w_idx   = awaddr[7:2];
  assign r_idx   = araddr[7:2];
  assign flush   = wr_fire & (w_idx == 6'd0) & wstrb[3] & wdata[31];
  assign full    = (level == FULL_LVL);
  assign empty   = (level == '0);
  assign pop     = rd_fire & (r_idx == 6'd2) & ~empty;
  assign head    = mem[rd_ptr];

  // Pick the selected debug tap; out-of-range selects never match
  always_comb begin
    dbg_valid  = 1'b0;
    dbg_sample = '0;
    for (int k = 0; k < CHANNELS; k++) begin
      if (sel == 4'(k)) begin
        dbg_valid  = debug_in_valid[k];
        dbg_sample = debug_in[k*DATA_WIDTH +: DATA_WIDTH];
      end
    end
  end

  assign push_req = enable & (src ? dbg_valid : y_in_valid);
  assign push_ok  = push_req & ~flush & (~full | pop);
  assign drop     = push_req & ~flush & full & ~pop;
  assign entry    = src ? {sel, dbg_sample} : {4'hF, y_in};

  // Register read mux, evaluated against pre-edge state
  always_comb begin
    rd_word = '0;
    rd_err  = 1'b0;
    unique case (r_idx)
      6'd0: rd_word = {23'd0, irq_en, sel, 2'b00, src, enable};
      6'd1: rd_word = {16'(level), 13'd0, overflow, full, empty};
      6'd2: if (!empty)
              rd_word = {1'b1, 3'b000, head[EW-1 -: 4],
                         24'($signed(head[DATA_WIDTH-1:0]))};
      6'd3: rd_word = push_cnt;
      6'd4: rd_word = drop_cnt;
      6'd5: rd_word = {16'd0, thresh};
      default: rd_err = 1'b1;
    endcase
  end

  // Write address/data handshake and response
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      awready <= 1'b0;
      wready  <= 1'b0;
      bvalid  <= 1'b0;
      bresp   <= 2'b00;
    end else begin
      if (wr_fire) begin
        awready <= 1'b0;
        wready  <= 1'b0;
        bvalid  <= 1'b1;
        bresp   <= (w_idx <= 6'd5) ? 2'b00 : 2'b10;
      end else if (!bvalid && !awready && awvalid && wvalid) begin
        awready <= 1'b1;
        wready  <= 1'b1;
      end
      if (bvalid && bready)
        bvalid <= 1'b0;
    end
  end

  // Read address handshake and registered response
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      arready <= 1'b0;
      rvalid  <= 1'b0;
      rdata   <= '0;
      rresp   <= 2'b00;
    end else begin
      if (rd_fire) begin
        arready <= 1'b0;
        rvalid  <= 1'b1;
        rdata   <= rd_word;
        rresp   <= rd_err ? 2'b10 : 2'b00;
      end else if (!rvalid && !arready && arvalid) begin
        arready <= 1'b1;
      end
      if (rvalid && rready)
        rvalid <= 1'b0;
    end
  end

  // Control and threshold registers with byte strobes
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      enable <= 1'b0;
      src    <= 1'b0;
      sel    <= '0;
      irq_en <= 1'b0;
      thresh <= '0;
    end else if (wr_fire) begin
      if (w_idx == 6'd0) begin
        if (wstrb[0]) begin
          enable <= wdata[0];
          src    <= wdata[1];
          sel    <= wdata[7:4];
        end
        if (wstrb[1])
          irq_en <= wdata[8];
      end
      if (w_idx == 6'd5) begin
        if (wstrb[0]) thresh[7:0]  <= wdata[7:0];
        if (wstrb[1]) thresh[15:8] <= wdata[15:8];
      end
    end
  end

  // FIFO pointers, level, counters and sticky overflow
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      level    <= '0;
      overflow <= 1'b0;
      push_cnt <= '0;
      drop_cnt <= '0;
    end else if (flush) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      level    <= '0;
      overflow <= 1'b0;
      push_cnt <= '0;
      drop_cnt <= '0;
    end else begin
      if (push_ok) begin
        wr_ptr   <= wr_ptr + 1'b1;
        push_cnt <= push_cnt + 32'd1;
      end
      if (pop)
        rd_ptr <= rd_ptr + 1'b1;
      if (push_ok && !pop)
        level <= level + 1'b1;
      else if (pop && !push_ok)
        level <= level - 1'b1;
      if (drop) begin
        drop_cnt <= drop_cnt + 32'd1;
        overflow <= 1'b1;
      end else if (wr_fire && w_idx == 6'd1 && wstrb[0] && wdata[2]) begin
        overflow <= 1'b0;
      end
    end
  end

  // Sample storage; contents need no reset
  always_ff @(posedge clk) begin
    if (push_ok)
      mem[wr_ptr] <= entry;
  end

  // Level interrupt, one cycle behind the level register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      irq <= 1'b0;
    else
      irq <= irq_en & (thresh != 16'd0) & (16'(level) >= thresh);
  end

endmodule

// File: tb/tb_axi4_lite_lstm_capture.sv
// Bench for axi4_lite_lstm_capture.
// Queue-based reference model plus directed literal checks.
module tb_axi4_lite_lstm_capture;

  localparam int DW = 16;
  localparam int CH = 4;
  localparam int DEPTH = 64;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic [31:0] awaddr = '0;
  logic [2:0] awprot = '0;
  logic awvalid = 1'b0;
  logic awready;
  logic [31:0] wdata = '0;
  logic [3:0] wstrb = '0;
  logic wvalid = 1'b0;
  logic wready;
  logic [1:0] bresp;
  logic bvalid;
  logic bready = 1'b1;
  logic [31:0] araddr = '0;
  logic [2:0] arprot = '0;
  logic arvalid = 1'b0;
  logic arready;
  logic [31:0] rdata;
  logic [1:0] rresp;
  logic rvalid;
  logic rready = 1'b1;
  logic [DW-1:0] y_in = '0;
  logic y_in_valid = 1'b0;
  logic [CH*DW-1:0] debug_in = '0;
  logic [CH-1:0] debug_in_valid = '0;
  logic irq;

  axi4_lite_lstm_capture #(
    .DATA_WIDTH(DW), .CHANNELS(CH), .FIFO_DEPTH(DEPTH)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .awaddr(awaddr), .awprot(awprot), .awvalid(awvalid),
    .awready(awready),
    .wdata(wdata), .wstrb(wstrb), .wvalid(wvalid), .wready(wready),
    .bresp(bresp), .bvalid(bvalid), .bready(bready),
    .araddr(araddr), .arprot(arprot), .arvalid(arvalid),
    .arready(arready),
    .rdata(rdata), .rresp(rresp), .rvalid(rvalid), .rready(rready),
    .y_in(y_in), .y_in_valid(y_in_valid),
    .debug_in(debug_in), .debug_in_valid(debug_in_valid),
    .irq(irq)
  );

  always #5 clk = ~clk;

  int vectors = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  task automatic tmo(input string name);
    vectors++;
    errors++;
    $display("FAIL %s: timeout waiting for handshake", name);
  endtask

  // ---------------- reference model ----------------
  logic [27:0] mq[$];
  logic [31:0] m_cnt, m_drop;
  bit m_ovf, m_en, m_src, m_ie, irq_exp;
  logic [3:0] m_sel;
  logic [15:0] m_th;
  logic [31:0] exp_r[$];
  logic [1:0] exp_rr[$];
  logic [1:0] exp_b[$];

  always @(posedge clk) begin : model
    int sz;
    bit pop, flush, preq;
    logic [27:0] e, e_new;
    logic [31:0] rv;
    logic [1:0] rr;
    logic [DW-1:0] tap;
    if (!rst_n) begin
      mq.delete();
      m_cnt = 0; m_drop = 0; m_ovf = 0;
      m_en = 0; m_src = 0; m_ie = 0; m_sel = 0; m_th = 0;
      irq_exp = 0;
    end else begin
      sz = mq.size();
      irq_exp = m_ie && (m_th != 0) && (sz >= int'(m_th));
      pop = 0;
      if (arvalid && arready) begin
        rv = 0; rr = 0;
        case (araddr[7:2])
          6'd0: rv = {23'd0, m_ie, m_sel, 2'b00, m_src, m_en};
          6'd1: rv = {16'(sz), 13'd0, m_ovf, sz == DEPTH, sz == 0};
          6'd2: if (sz > 0) begin
                  e = mq.pop_front();
                  pop = 1;
                  rv = {4'b1000, e};
                end
          6'd3: rv = m_cnt;
          6'd4: rv = m_drop;
          6'd5: rv = {16'd0, m_th};
          default: rr = 2'b10;
        endcase
        exp_r.push_back(rv);
        exp_rr.push_back(rr);
      end
      preq = 0;
      e_new = 0;
      if (m_en && !m_src) begin
        preq = y_in_valid;
        e_new = {4'hF, 24'($signed(y_in))};
      end else if (m_en && m_src && m_sel < CH) begin
        tap = debug_in[m_sel*DW +: DW];
        preq = debug_in_valid[m_sel];
        e_new = {m_sel, 24'($signed(tap))};
      end
      flush = 0;
      if (awvalid && awready && wvalid && wready) begin
        exp_b.push_back(awaddr[7:2] <= 6'd5 ? 2'b00 : 2'b10);
        case (awaddr[7:2])
          6'd0: begin
            if (wstrb[0]) begin
              m_en = wdata[0]; m_src = wdata[1]; m_sel = wdata[7:4];
            end
            if (wstrb[1]) m_ie = wdata[8];
            flush = wstrb[3] && wdata[31];
          end
          6'd1: if (wstrb[0] && wdata[2]) m_ovf = 0;
          6'd5: begin
            if (wstrb[0]) m_th[7:0] = wdata[7:0];
            if (wstrb[1]) m_th[15:8] = wdata[15:8];
          end
          default: ;
        endcase
      end
      if (flush) begin
        mq.delete();
        m_cnt = 0; m_drop = 0; m_ovf = 0;
      end else if (preq) begin
        if (sz < DEPTH || pop) begin
          mq.push_back(e_new);
          m_cnt++;
        end else begin
          m_drop++;
          m_ovf = 1;
        end
      end
    end
  end

  // ---------------- compare process ----------------
  always @(negedge clk) begin
    #2;
    if (rst_n) begin
      chk("irq", {31'd0, irq}, {31'd0, irq_exp});
      if (rvalid && rready) begin
        if (exp_r.size() == 0) begin
          tmo("unexpected_rvalid");
        end else begin
          chk("rdata", rdata, exp_r.pop_front());
          chk("rresp", {30'd0, rresp}, {30'd0, exp_rr.pop_front()});
        end
      end
      if (bvalid && bready) begin
        if (exp_b.size() == 0) tmo("unexpected_bvalid");
        else chk("bresp", {30'd0, bresp}, {30'd0, exp_b.pop_front()});
      end
    end
  end

  // ---------------- bus tasks ----------------
  task automatic axi_write(input logic [31:0] a, input logic [31:0] d,
                           input logic [3:0] s, input bit wait_b);
    int t;
    @(negedge clk);
    awaddr = a; wdata = d; wstrb = s;
    awvalid = 1; wvalid = 1;
    t = 0;
    do begin @(negedge clk); t++; end while (!awready && t < 50);
    if (!awready) begin
      tmo("awready");
      awvalid = 0; wvalid = 0;
      return;
    end
    @(negedge clk);
    awvalid = 0; wvalid = 0;
    if (wait_b) begin
      t = 0;
      while (bvalid && t < 50) begin @(negedge clk); t++; end
      if (bvalid) tmo("bvalid_clear");
    end
  endtask

  task automatic axi_read(input logic [31:0] a, input bit push_acc,
                          output logic [31:0] d, output logic [1:0] r);
    int t;
    d = 0; r = 0;
    @(negedge clk);
    araddr = a; arvalid = 1;
    t = 0;
    do begin @(negedge clk); t++; end while (!arready && t < 50);
    if (!arready) begin
      tmo("arready");
      arvalid = 0;
      return;
    end
    if (push_acc) begin y_in = 16'h0077; y_in_valid = 1; end
    @(negedge clk);
    arvalid = 0;
    if (push_acc) y_in_valid = 0;
    t = 0;
    while (!rvalid && t < 50) begin @(negedge clk); t++; end
    if (!rvalid) begin tmo("rvalid"); return; end
    d = rdata; r = rresp;
  endtask

  task automatic rd_chk(input string n, input logic [31:0] a,
                        input logic [31:0] exp);
    logic [31:0] d;
    logic [1:0] r;
    axi_read(a, 0, d, r);
    chk(n, d, exp);
  endtask

  task automatic pulse_y(input logic [15:0] v);
    @(negedge clk);
    y_in = v; y_in_valid = 1;
    @(negedge clk);
    y_in_valid = 0;
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin : main
    logic [31:0] d;
    logic [1:0] r;
    logic [31:0] ra[9];
    bit done;
    int t;
    ra = '{32'h00, 32'h04, 32'h08, 32'h08, 32'h08,
           32'h0C, 32'h10, 32'h14, 32'h40};
    repeat (4) @(negedge clk);
    rst_n = 1;
    @(negedge clk);
    // 1: reset state
    chk("rst_awready", {31'd0, awready}, 0);
    chk("rst_wready", {31'd0, wready}, 0);
    chk("rst_bvalid", {31'd0, bvalid}, 0);
    chk("rst_arready", {31'd0, arready}, 0);
    chk("rst_rvalid", {31'd0, rvalid}, 0);
    chk("rst_rdata", rdata, 0);
    chk("rst_irq", {31'd0, irq}, 0);
    rd_chk("rst_status", 32'h04, 32'h0000_0001);
    // 2: single y_in capture
    axi_write(32'h00, 32'h1, 4'hF, 1);
    pulse_y(16'hFFFD);
    rd_chk("lvl1_status", 32'h04, 32'h0001_0000);
    rd_chk("y_data", 32'h08, 32'h8FFF_FFFD);
    rd_chk("y_count", 32'h0C, 32'd1);
    rd_chk("y_empty", 32'h04, 32'h0000_0001);
    rd_chk("empty_data", 32'h08, 32'h0);
    // 3: debug channel select
    axi_write(32'h00, 32'h23, 4'hF, 1);
    @(negedge clk);
    debug_in = {16'h4444, 16'h1234, 16'h2222, 16'h1111};
    debug_in_valid = 4'b0111;
    @(negedge clk);
    debug_in_valid = 0;
    rd_chk("dbg_data", 32'h08, 32'h8200_1234);
    rd_chk("dbg_empty", 32'h04, 32'h0000_0001);
    axi_write(32'h00, 32'h53, 4'hF, 1);
    @(negedge clk);
    debug_in_valid = 4'b1111;
    @(negedge clk);
    debug_in_valid = 0;
    rd_chk("sel5_none", 32'h04, 32'h0000_0001);
    rd_chk("ctrl_rb", 32'h00, 32'h0000_0053);
    rd_chk("dbg_count", 32'h0C, 32'd2);
    // 4: fill, overflow, push+pop at full
    axi_write(32'h00, 32'h1, 4'hF, 1);
    for (int i = 0; i < DEPTH + 3; i++) begin
      @(negedge clk);
      y_in = 16'(i); y_in_valid = 1;
    end
    @(negedge clk);
    y_in_valid = 0;
    rd_chk("full_drop", 32'h10, 32'd3);
    rd_chk("full_status", 32'h04, 32'h0040_0006);
    axi_read(32'h08, 1, d, r);
    chk("full_pop", d, 32'h8F00_0000);
    rd_chk("pp_drop", 32'h10, 32'd3);
    rd_chk("pp_status", 32'h04, 32'h0040_0006);
    rd_chk("pp_count", 32'h0C, 32'd67);
    // 5: flush then threshold interrupt
    axi_write(32'h00, 32'h8000_0001, 4'hF, 1);
    rd_chk("flush_status", 32'h04, 32'h0000_0001);
    rd_chk("flush_count", 32'h0C, 32'd0);
    axi_write(32'h14, 32'd4, 4'hF, 1);
    axi_write(32'h00, 32'h101, 4'hF, 1);
    for (int i = 0; i < 4; i++) pulse_y(16'(i + 10));
    chk("irq_lag", {31'd0, irq}, 0);
    @(negedge clk);
    chk("irq_rise", {31'd0, irq}, 1);
    axi_read(32'h08, 0, d, r);
    chk("irq_pop", d, 32'h8F00_000A);
    chk("irq_hold", {31'd0, irq}, 1);
    @(negedge clk);
    chk("irq_fall", {31'd0, irq}, 0);
    // 6: unmapped read and write backpressure
    axi_read(32'h40, 0, d, r);
    chk("slverr", {30'd0, r}, 32'd2);
    bready = 0;
    axi_write(32'h14, 32'd0, 4'hF, 0);
    @(negedge clk);
    awaddr = 32'h14; wdata = 32'd5; wstrb = 4'hF;
    awvalid = 1; wvalid = 1;
    repeat (5) begin
      @(negedge clk);
      chk("b_hold", {31'd0, bvalid}, 1);
      chk("aw_block", {31'd0, awready}, 0);
    end
    bready = 1;
    t = 0;
    while (!awready && t < 50) begin @(negedge clk); t++; end
    if (!awready) tmo("aw2");
    @(negedge clk);
    awvalid = 0; wvalid = 0;
    t = 0;
    while (bvalid && t < 50) begin @(negedge clk); t++; end
    rd_chk("thresh_rb", 32'h14, 32'd5);
    // random phase
    done = 0;
    fork
      begin
        for (int c = 0; c < 3000; c++) begin
          @(negedge clk);
          y_in = 16'($urandom);
          y_in_valid = 1'($urandom);
          debug_in = {$urandom, $urandom};
          debug_in_valid = 4'($urandom);
        end
        @(negedge clk);
        y_in_valid = 0; debug_in_valid = 0;
        done = 1;
      end
      begin
        while (!done) begin
          int op;
          logic [31:0] wd;
          logic [3:0] st;
          op = $urandom_range(0, 11);
          st = ($urandom_range(0, 3) == 0) ? 4'($urandom) : 4'hF;
          if (op == 0) begin
            wd = 0;
            wd[0] = ($urandom_range(0, 3) != 0);
            wd[1] = 1'($urandom);
            wd[7:4] = 4'($urandom_range(0, 5));
            wd[8] = 1'($urandom);
            wd[31] = ($urandom_range(0, 9) == 0);
            axi_write(32'h00, wd, st, 1);
          end else if (op == 1) begin
            axi_write(32'h14, 32'($urandom_range(0, 70)), st, 1);
          end else if (op == 2) begin
            axi_write(32'h04, 32'h4, st, 1);
          end else if (op == 3) begin
            axi_write({$urandom_range(6, 63), 2'b00} |
                      ($urandom & 32'hFFFF_FF00), $urandom, st, 1);
          end else begin
            axi_read(ra[$urandom_range(0, 8)] |
                     ($urandom & 32'hFFFF_FF00), 0, d, r);
          end
        end
      end
    join
    repeat (5) @(negedge clk);
    $display("== %0d vectors applied, %0d miscompares ==",
             vectors, errors);
    $finish;
  end

endmodule
